// File: rtl/sram_ctr_ahb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sram_ctr_ahb_pkg: shared encodings and the byte-enable helper.
// Revision: 1.0
// ---------------------------------------------------------------------------
package sram_ctr_ahb_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE  = 2'b00,
    STATE_WRITE = 2'b01,
    STATE_WR2RD = 2'b11,
    STATE_READ  = 2'b10
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] SIZE_BYTE = 3'd0;
  localparam logic [2:0] SIZE_HALF = 3'd1;
  localparam logic [2:0] SIZE_WORD = 3'd2;

  // Lane mask shifted by the byte offset; lanes beyond bit 3 fall off.
  function automatic logic [3:0] calc_be(input logic [1:0] lo, input logic [2:0] size);
    logic [3:0] mask;
    case (size)
      SIZE_BYTE: mask = 4'b0001;
      SIZE_HALF: mask = 4'b0011;
      default:   mask = 4'b1111;
    endcase
    return mask << lo;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_ctr_ahb_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sram_ctr_ahb_decode: address-phase decode (byte enables, word address, error).
// Error detection only with SRAM_CTR_AHB_ERR_EN defined. Revision: 1.0
// ---------------------------------------------------------------------------
module sram_ctr_ahb_decode
  import sram_ctr_ahb_pkg::*;
#(
  parameter int MEM_AW = 12
) (
  input  logic [31:0]       i_haddr,
  input  logic [2:0]        i_hsize,
  output logic [3:0]        o_be,
  output logic              o_err,
  output logic [MEM_AW-1:0] o_waddr
);

  assign o_be    = calc_be(i_haddr[1:0], i_hsize);
  assign o_waddr = i_haddr[MEM_AW+1:2];

`ifdef SRAM_CTR_AHB_ERR_EN
  logic w_size_err, w_align_err, w_range_err;
  assign w_size_err  = (i_hsize > SIZE_WORD);
  assign w_align_err = ((i_hsize == SIZE_HALF) && i_haddr[0]) ||
                       ((i_hsize == SIZE_WORD) && (i_haddr[1:0] != 2'b00));
  assign w_range_err = (i_haddr[31:MEM_AW+2] != '0);
  assign o_err       = w_size_err | w_align_err | w_range_err;
`else
  logic w_unused_hi;
  // Upper address bits are ignored: the address wraps over the SRAM.
  assign w_unused_hi = ^i_haddr[31:MEM_AW+2];
  assign o_err       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/sram_ctr_ahb_dp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sram_ctr_ahb_dp: AHB-Lite data path to a 1-cycle-latency single-port SRAM.
// Optional error response: SRAM_CTR_AHB_ERR_EN. Revision: 1.0
// ---------------------------------------------------------------------------
module sram_ctr_ahb_dp
  import sram_ctr_ahb_pkg::*;
#(
  parameter int MEM_AW = 12
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              i_hsel,
  input  logic              i_hready_in,
  input  logic [1:0]        i_htrans,
  input  logic              i_hwrite,
  input  logic [2:0]        i_hsize,
  input  logic [31:0]       i_haddr,
  input  logic [31:0]       i_hwdata,
  input  logic [1:0]        i_state,
  output logic              o_hreadyout,
  output logic              o_hresp,
  output logic [31:0]       o_hrdata,
  output logic              o_error_check,
  output logic              o_sram_cs_n,
  output logic              o_sram_we_n,
  output logic [MEM_AW-1:0] o_sram_addr,
  output logic [3:0]        o_sram_be,
  output logic [31:0]       o_sram_wdata,
  input  logic [31:0]       i_sram_rdata
);

  logic              w_accept, w_err, w_wr_phase, w_rd_now, w_rd_defer, w_unused;
  logic [3:0]        w_be;
  logic [MEM_AW-1:0] w_waddr;

  logic [MEM_AW+1:0] r_ap_addr;
  logic [2:0]        r_ap_size;
  logic              r_ap_write, r_ap_valid;

  sram_ctr_ahb_decode #(.MEM_AW(MEM_AW)) u_decode (
    .i_haddr (i_haddr),
    .i_hsize (i_hsize),
    .o_be    (w_be),
    .o_err   (w_err),
    .o_waddr (w_waddr)
  );

  assign w_accept   = i_hsel & i_hready_in & i_htrans[1];
  assign w_wr_phase = (i_state == STATE_WRITE) & r_ap_valid & r_ap_write;
  // A read colliding with a write data phase waits in ap_* for WR2RD.
  assign w_rd_now   = w_accept & ~w_err & ~i_hwrite & ~w_wr_phase;
  assign w_rd_defer = (i_state == STATE_WR2RD) & r_ap_valid & ~r_ap_write;
  assign w_unused   = i_htrans[0];

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_ap_addr  <= '0;
      r_ap_size  <= '0;
      r_ap_write <= 1'b0;
      r_ap_valid <= 1'b0;
    end else if (w_accept) begin
      r_ap_addr  <= i_haddr[MEM_AW+1:0];
      r_ap_size  <= i_hsize;
      r_ap_write <= i_hwrite;
      r_ap_valid <= ~w_err;
    end else if (i_hready_in) begin
      r_ap_valid <= 1'b0;
    end
  end

  always_comb begin
    o_sram_cs_n  = 1'b1;
    o_sram_we_n  = 1'b1;
    o_sram_addr  = '0;
    o_sram_be    = 4'b0000;
    o_sram_wdata = '0;
    if (w_wr_phase) begin
      o_sram_cs_n  = 1'b0;
      o_sram_we_n  = 1'b0;
      o_sram_addr  = r_ap_addr[MEM_AW+1:2];
      o_sram_be    = calc_be(r_ap_addr[1:0], r_ap_size);
      o_sram_wdata = i_hwdata;
    end else if (w_rd_defer) begin
      o_sram_cs_n = 1'b0;
      o_sram_addr = r_ap_addr[MEM_AW+1:2];
      o_sram_be   = calc_be(r_ap_addr[1:0], r_ap_size);
    end else if (w_rd_now) begin
      o_sram_cs_n = 1'b0;
      o_sram_addr = w_waddr;
      o_sram_be   = w_be;
    end
  end

  assign o_hrdata = (i_state == STATE_READ) ? i_sram_rdata : 32'h0;

`ifdef SRAM_CTR_AHB_ERR_EN
  logic r_err1, r_err2;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_err1 <= 1'b0;
      r_err2 <= 1'b0;
    end else begin
      r_err1 <= w_accept & w_err;
      r_err2 <= r_err1;
    end
  end

  assign o_error_check = w_accept & w_err;
  assign o_hresp       = r_err1 | r_err2;
  assign o_hreadyout   = ~r_err1 & ~w_rd_defer;
`else
  assign o_error_check = 1'b0;
  assign o_hresp       = 1'b0;
  assign o_hreadyout   = ~w_rd_defer;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_ctr_ahb_dp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sram_ctr_ahb_dp: directed bench with SRAM model and read-data scoreboard.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_sram_ctr_ahb_dp;
  import sram_ctr_ahb_pkg::*;

  localparam int MEM_AW = 12;
  localparam int DEPTH  = 1 << MEM_AW;

  logic              hclk = 1'b0;
  logic              hresetn;
  logic              i_hsel, i_hwrite;
  wire logic         i_hready_in;
  logic [1:0]        i_htrans, i_state;
  logic [2:0]        i_hsize;
  logic [31:0]       i_haddr, i_hwdata;
  logic              o_hreadyout, o_hresp, o_error_check, o_sram_cs_n, o_sram_we_n;
  logic [31:0]       o_hrdata, o_sram_wdata, i_sram_rdata;
  logic [MEM_AW-1:0] o_sram_addr;
  logic [3:0]        o_sram_be;

  logic [31:0] sram_mem [DEPTH];
  logic [31:0] ref_mem  [DEPTH];
  logic [31:0] exp_q [$];
  int n_checks = 0;
  int n_errors = 0;
  int n_rd_strobes = 0;
  int rd_before;

  always #5 hclk = ~hclk;
  assign i_hready_in = o_hreadyout;

  sram_ctr_ahb_dp #(.MEM_AW(MEM_AW)) dut (
    .hclk(hclk), .hresetn(hresetn), .i_hsel(i_hsel), .i_hready_in(i_hready_in),
    .i_htrans(i_htrans), .i_hwrite(i_hwrite), .i_hsize(i_hsize), .i_haddr(i_haddr),
    .i_hwdata(i_hwdata), .i_state(i_state), .o_hreadyout(o_hreadyout), .o_hresp(o_hresp),
    .o_hrdata(o_hrdata), .o_error_check(o_error_check), .o_sram_cs_n(o_sram_cs_n),
    .o_sram_we_n(o_sram_we_n), .o_sram_addr(o_sram_addr), .o_sram_be(o_sram_be),
    .o_sram_wdata(o_sram_wdata), .i_sram_rdata(i_sram_rdata)
  );

  // Synchronous single-port SRAM, one cycle read latency.
  always @(posedge hclk) begin
    if (!o_sram_cs_n) begin
      if (!o_sram_we_n) begin
        for (int b = 0; b < 4; b++)
          if (o_sram_be[b]) sram_mem[o_sram_addr][8*b +: 8] <= o_sram_wdata[8*b +: 8];
      end else begin
        i_sram_rdata <= sram_mem[o_sram_addr];
        n_rd_strobes <= n_rd_strobes + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s: observed %h expected <scoreboard empty>", tag, o_hrdata);
    end else begin
      chk(tag, o_hrdata, exp_q.pop_front());
    end
  endtask

  task automatic set_bus(input logic sel, input logic [1:0] tr, input logic wr,
                         input logic [2:0] sz, input logic [31:0] a,
                         input logic [1:0] st, input logic [31:0] wd);
    i_hsel = sel; i_htrans = tr; i_hwrite = wr; i_hsize = sz;
    i_haddr = a; i_state = st; i_hwdata = wd;
  endtask

  task automatic idle_bus(input logic [1:0] st);
    set_bus(1'b0, HTRANS_IDLE, 1'b0, SIZE_WORD, 32'h0, st, 32'h0);
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hreadyout"}, o_hreadyout, 1);
    chk({tag, "_hresp"}, o_hresp, 0);
    chk({tag, "_hrdata"}, o_hrdata, 0);
    chk({tag, "_errchk"}, o_error_check, 0);
    chk({tag, "_cs_n"}, o_sram_cs_n, 1);
    chk({tag, "_we_n"}, o_sram_we_n, 1);
    chk({tag, "_addr"}, o_sram_addr, 0);
    chk({tag, "_be"}, o_sram_be, 0);
    chk({tag, "_wdata"}, o_sram_wdata, 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      sram_mem[i] = 32'h1000_0000 + i;
      ref_mem[i]  = 32'h1000_0000 + i;
    end
    i_sram_rdata = 32'h0;
    hresetn = 1'b0;
    idle_bus(STATE_IDLE);
    #2;
    chk_reset_vals("rst");
    step();
    hresetn = 1'b1;

    // Word write 0x4, then read 0x4 during the write data phase
    set_bus(1, HTRANS_NONSEQ, 1, SIZE_WORD, 32'h4, STATE_IDLE, 32'h0);
    #2 chk("wr_ap_cs_n", o_sram_cs_n, 1);
    step();
    set_bus(1, HTRANS_NONSEQ, 0, SIZE_WORD, 32'h4, STATE_WRITE, 32'hDEAD_BEEF);
    #2;
    chk("wr_we_n", o_sram_we_n, 0);
    chk("wr_cs_n", o_sram_cs_n, 0);
    chk("wr_addr", o_sram_addr, 1);
    chk("wr_be", o_sram_be, 4'b1111);
    chk("wr_wdata", o_sram_wdata, 32'hDEAD_BEEF);
    chk("wr_hready", o_hreadyout, 1);
    ref_mem[1] = 32'hDEAD_BEEF;
    exp_q.push_back(ref_mem[1]);
    step();
    idle_bus(STATE_WR2RD);
    #2;
    chk("wr2rd_hready", o_hreadyout, 0);
    chk("wr2rd_cs_n", o_sram_cs_n, 0);
    chk("wr2rd_we_n", o_sram_we_n, 1);
    chk("wr2rd_addr", o_sram_addr, 1);
    step();

    // READ data phase; byte write to 0x7 accepted in the same cycle (R->W)
    set_bus(1, HTRANS_NONSEQ, 1, SIZE_BYTE, 32'h7, STATE_READ, 32'h0);
    #2;
    chk("rd1_hready", o_hreadyout, 1);
    pop_chk("rd1_data");
    step();
    idle_bus(STATE_WRITE);
    i_hwdata = 32'hAB00_0000;
    #2;
    chk("bw_be", o_sram_be, 4'b1000);
    chk("bw_addr", o_sram_addr, 1);
    chk("bw_we_n", o_sram_we_n, 0);
    ref_mem[1][31:24] = 8'hAB;
    step();

    // Back-to-back reads of 0x0 and 0x4
    set_bus(1, HTRANS_NONSEQ, 0, SIZE_WORD, 32'h0, STATE_IDLE, 32'h0);
    #2;
    chk("rr0_cs_n", o_sram_cs_n, 0);
    chk("rr0_addr", o_sram_addr, 0);
    chk("rr0_hready", o_hreadyout, 1);
    chk("idle_hrdata", o_hrdata, 0);
    exp_q.push_back(ref_mem[0]);
    step();
    set_bus(1, HTRANS_NONSEQ, 0, SIZE_WORD, 32'h4, STATE_READ, 32'h0);
    #2;
    chk("rr1_cs_n", o_sram_cs_n, 0);
    chk("rr1_addr", o_sram_addr, 1);
    chk("rr1_hready", o_hreadyout, 1);
    pop_chk("rr0_data");
    exp_q.push_back(ref_mem[1]);
    step();
    idle_bus(STATE_READ);
    #2;
    chk("rr1_hready2", o_hreadyout, 1);
    chk("rr1_abad", o_hrdata, 32'hABAD_BEEF);
    pop_chk("rr1_data");
    step();

    // BUSY is never accepted
    set_bus(1, HTRANS_BUSY, 0, SIZE_WORD, 32'h4, STATE_IDLE, 32'h0);
    #2 chk("busy_cs_n", o_sram_cs_n, 1);
    step();
    idle_bus(STATE_IDLE);
    #2 chk("busy_hrdata", o_hrdata, 0);
    step();

`ifdef SRAM_CTR_AHB_ERR_EN
    for (int k = 0; k < 2; k++) begin
      set_bus(1, HTRANS_NONSEQ, 0, SIZE_WORD, (k == 0) ? 32'h2 : 32'h0001_0000,
              STATE_IDLE, 32'h0);
      #2;
      chk("err_pulse", o_error_check, 1);
      chk("err_cs_n0", o_sram_cs_n, 1);
      step();
      set_bus(1, HTRANS_NONSEQ, 0, SIZE_WORD, 32'h0, STATE_IDLE, 32'h0);
      #2;
      chk("err_c1_hresp", o_hresp, 1);
      chk("err_c1_hready", o_hreadyout, 0);
      chk("err_c1_cs_n", o_sram_cs_n, 1);
      step();
      idle_bus(STATE_IDLE);
      #2;
      chk("err_c2_hresp", o_hresp, 1);
      chk("err_c2_hready", o_hreadyout, 1);
      chk("err_c2_cs_n", o_sram_cs_n, 1);
      step();
      #2 chk("err_done_hresp", o_hresp, 0);
    end
`else
    set_bus(1, HTRANS_NONSEQ, 0, SIZE_WORD, 32'h0001_0000, STATE_IDLE, 32'h0);
    #2;
    chk("wrap_errchk", o_error_check, 0);
    chk("wrap_cs_n", o_sram_cs_n, 0);
    chk("wrap_addr", o_sram_addr, 0);
    exp_q.push_back(ref_mem[0]);
    step();
    set_bus(1, HTRANS_NONSEQ, 0, SIZE_WORD, 32'h2, STATE_READ, 32'h0);
    #2;
    chk("wrap_hresp", o_hresp, 0);
    pop_chk("wrap_data");
    chk("mis_be", o_sram_be, 4'b1100);
    chk("mis_addr", o_sram_addr, 0);
    exp_q.push_back(ref_mem[0]);
    step();
    idle_bus(STATE_READ);
    #2 pop_chk("mis_data");
    step();
`endif

    // Reset asserted during the WR2RD stall drops the pending read
    idle_bus(STATE_IDLE);
    set_bus(1, HTRANS_NONSEQ, 1, SIZE_WORD, 32'h8, STATE_IDLE, 32'h0);
    step();
    set_bus(1, HTRANS_NONSEQ, 0, SIZE_WORD, 32'h8, STATE_WRITE, 32'h1234_5678);
    #2 chk("rw_we_n", o_sram_we_n, 0);
    ref_mem[2] = 32'h1234_5678;
    step();
    idle_bus(STATE_WR2RD);
    #2 chk("rw_stall", o_hreadyout, 0);
    rd_before = n_rd_strobes;
    hresetn = 1'b0;
    i_state = STATE_IDLE;
    #1 chk_reset_vals("mid_rst");
    step();
    #2 chk_reset_vals("mid_rst2");
    chk("mid_rst_nostrobe", n_rd_strobes, rd_before);
    hresetn = 1'b1;
    step();
    #2;
    chk("post_rst_cs_n", o_sram_cs_n, 1);
    chk("post_rst_nostrobe", n_rd_strobes, rd_before);
    chk("sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_ctr_ahb_dp.md
# sram_ctr_ahb_dp

AHB-Lite data-path stage of the SRAM controller, downstream of the controller state machine. It consumes the 2-bit `state` the FSM produces and the AHB address and data phases. It drives a single-port synchronous SRAM (1-cycle read latency) and returns `hreadyout`, `hresp` and `hrdata`. It also produces `error_check`, which feeds back into the FSM.

## Interface
- `MEM_AW`, default 12: SRAM word-address width; capacity is 4·2^MEM_AW bytes.
- `hclk`  in  1  clock.
- `hresetn`  in  1  reset, asynchronous, active-low.
- `hsel`, `hready_in`  in  1 each  slave select; bus ready.
- `htrans`  in  2  AHB transfer type.
- `hwrite`  in  1  write when 1.
- `hsize`  in  3  transfer size.
- `haddr`  in  32  byte address.
- `hwdata`  in  32  write data.
- `state`  in  2  FSM state: IDLE=00, WRITE=01, WR2RD=11, READ=10.
- `hreadyout`, `hresp`  out  1 each  transfer ready; error response.
- `hrdata`  out  32  read data.
- `error_check`  out  1  to FSM; forces FSM to IDLE.
- `sram_cs_n`, `sram_we_n`  out  1 each  chip select and write enable, both active-low.
- `sram_addr`  out  MEM_AW  word address.
- `sram_be`  out  4  byte enables.
- `sram_wdata`  out  32  write data.
- `sram_rdata`  in  32  valid one cycle after a read strobe.

## Operation
- Accept: `hsel & hready_in & htrans[1]`. On accept, register `ap_addr`, `ap_size` and `ap_write`, and set `ap_valid`. `ap_valid` clears on a cycle with `hready_in=1` and no accept.
- Byte enables:
  - hsize=0: `be = 1<<addr[1:0]`.
  - hsize=1: 0011 when `addr[1]=0`, else 1100.
  - hsize=2: 1111.
- Error at accept, any of:
  - `hsize>2`;
  - hsize=1 with `addr[0]=1`;
  - hsize=2 with `addr[1:0]≠0`;
  - `haddr[31:MEM_AW+2]≠0`.
- `error_check` is combinational: asserted in the accept cycle of an erroring transfer. No SRAM access is issued for that transfer.
- Write: SRAM write strobe in the data-phase cycle (`state==WRITE & ap_valid & ap_write`). `sram_addr`, `sram_be` and `sram_wdata` come from the `ap_*` registers and `hwdata`. Zero wait states.
- Read: the SRAM read strobe is issued combinationally from `haddr` in the accept cycle. In the data phase (`state==READ`), `hrdata = sram_rdata`. Zero wait states.
- Write-then-read conflict: a read accepted while a write data phase is active is not issued in that cycle; its address is held in `ap_addr`.
  - Next cycle (`state==WR2RD`): `hreadyout=0`, read strobe issued from `ap_addr`.
  - Following cycle (`state==READ`): `hreadyout=1`, `hrdata` valid.
- Idle: `sram_cs_n=1`, `sram_we_n=1`, `hrdata=0` outside read data phases.

## Timing
- Reset values: `hreadyout=1`, `hresp=0`, `hrdata=0`, `error_check=0`, `sram_cs_n=1`, `sram_we_n=1`, `sram_addr=0`, `sram_be=0`, `sram_wdata=0`; all `ap_*` registers 0.
- Error response after an erroring accept:
  - cycle 1: `hresp=1`, `hreadyout=0`;
  - cycle 2: `hresp=1`, `hreadyout=1`.
  - A transfer presented during cycle 1 is not accepted, because `hready_in` is low.
- Latency: write 0 wait states. Read 0 wait states, or 1 wait state after a write data phase.
- Back-to-back mixes:
  - W→W, R→R and R→W: no stall.
  - W→R: exactly one stall cycle.
- Reset mid-transfer: everything returns to reset values immediately. A pending WR2RD read is dropped, with no SRAM strobe.
- `htrans=BUSY` is never accepted and creates no access.

## Configuration
- `SRAM_CTR_AHB_ERR_EN` defined: error detection and the two-cycle ERROR response as above.
- Undefined:
  - `error_check` is tied 0 and `hresp` is tied 0;
  - the address wraps modulo 2^MEM_AW words;
  - misaligned accesses use `haddr[1:0]` with `be` truncated to the bus lanes;
  - `hsize>2` is treated as a word access.

## Structure
- Package `sram_ctr_ahb_pkg` holds:
  - state encodings `STATE_IDLE/WRITE/WR2RD/READ`;
  - htrans codes `IDLE/BUSY/NONSEQ/SEQ`;
  - hsize codes `SIZE_BYTE/HALF/WORD`.
- Sub-module `sram_ctr_ahb_decode` (combinational): inputs `haddr`, `hsize`; outputs `be[3:0]`, `err`, word address.

## Test plan
- Write 0x0000_0004 hsize=2 data 0xDEADBEEF, then read 0x4 → one stall cycle in WR2RD; `hrdata=0xDEADBEEF` with `hreadyout=1`.
- Byte write 0xAB to 0x0000_0007 → `sram_be=1000`, `sram_addr=1`; a later word read of 0x4 returns 0xABADBEEF.
- Back-to-back reads of 0x0 then 0x4 → zero wait states, data returned in consecutive cycles.
- Word access to 0x0000_0002, and access to 0x0001_0000 with MEM_AW=12 → `error_check` pulse, two-cycle ERROR, no `sram_cs_n` low.
- `hresetn` low during the WR2RD stall → next cycle all outputs at reset values, no SRAM read strobe.
- Build without `SRAM_CTR_AHB_ERR_EN`: access to 0x0001_0000 → SRAM word 0 accessed, `hresp=0`.
